// File: rtl/algo_1r4wt_a662_wr_issuer_if.sv
// rtl/algo_1r4wt_a662_wr_issuer_if.sv - client stream and memory write-port bundle for the write issuer
interface algo_1r4wt_a662_wr_issuer_if #(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int NUMWRPT = 4,
    parameter int BITFIFO = 6
);
    logic                       cl_vld;
    logic [BITADDR-1:0]         cl_adr;
    logic [WIDTH-1:0]           cl_din;
    logic                       cl_rdy;
    logic [BITFIFO:0]           cfg_thr;
    logic                       ready;
    logic [NUMWRPT-1:0]         wr_bp;
    logic [BITFIFO:0]           bp_thr;
    logic [NUMWRPT-1:0]         write;
    logic [NUMWRPT*BITADDR-1:0] wr_adr;
    logic [NUMWRPT*WIDTH-1:0]   din;
    logic [BITFIFO:0]           q_cnt;

    modport master (
        output cl_vld, cl_adr, cl_din, cfg_thr, ready, wr_bp,
        input  cl_rdy, bp_thr, write, wr_adr, din, q_cnt
    );

    modport slave (
        input  cl_vld, cl_adr, cl_din, cfg_thr, ready, wr_bp,
        output cl_rdy, bp_thr, write, wr_adr, din, q_cnt
    );
endinterface

// File: rtl/algo_1r4wt_a662_wr_issuer.sv
// rtl/algo_1r4wt_a662_wr_issuer.sv - queues client writes and packs them onto the 1R4W memory write ports
module algo_1r4wt_a662_wr_issuer #(
    parameter int WIDTH   = 32,
    parameter int BITADDR = 13,
    parameter int NUMWRPT = 4,
    parameter int FIFOCNT = 64,
    parameter int BITFIFO = 6
) (
    input logic                      clk,
    input logic                      rst,
    algo_1r4wt_a662_wr_issuer_if.slave bus
);
    localparam int EW = BITADDR + WIDTH;

    typedef enum logic [1:0] {INIT, RUN, STALL} state_t;

    state_t                     state, state_nxt;
    logic [EW-1:0]              mem [FIFOCNT];
    logic [BITFIFO-1:0]         rd_ptr, wr_ptr;
    logic [BITFIFO:0]           cnt, cnt_nxt, k, pop_cnt;
    logic                       cl_rdy_q;
    logic [BITFIFO:0]           bp_thr_q;
    logic [NUMWRPT-1:0]         write_q, sel;
    logic [NUMWRPT*BITADDR-1:0] wr_adr_q, lane_adr;
    logic [NUMWRPT*WIDTH-1:0]   din_q, lane_din;
    logic [EW-1:0]              ent;
    logic                       push, issue_en, stop, dup;

    assign bus.cl_rdy = cl_rdy_q;
    assign bus.bp_thr = bp_thr_q;
    assign bus.write  = write_q;
    assign bus.wr_adr = wr_adr_q;
    assign bus.din    = din_q;
    assign bus.q_cnt  = cnt;

    assign push     = bus.cl_vld && cl_rdy_q;
    assign issue_en = (state == RUN) && bus.ready && (bus.wr_bp == '0);
    assign pop_cnt  = issue_en ? k : '0;
    assign cnt_nxt  = cnt + {{BITFIFO{1'b0}}, push} - pop_cnt;

    // Next-state logic; losing ready always wins over lane backpressure.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (bus.ready) state_nxt = RUN;
            RUN: begin
                if (!bus.ready)       state_nxt = INIT;
                else if (|bus.wr_bp)  state_nxt = STALL;
            end
            STALL: begin
                if (!bus.ready)            state_nxt = INIT;
                else if (bus.wr_bp == '0)  state_nxt = RUN;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Pick the longest in-order run of head entries with no repeated address.
    always_comb begin
        sel      = '0;
        k        = '0;
        lane_adr = '0;
        lane_din = '0;
        stop     = 1'b0;
        dup      = 1'b0;
        ent      = '0;
        for (int i = 0; i < NUMWRPT; i++) begin
            ent = mem[rd_ptr + BITFIFO'(i)];
            dup = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (lane_adr[j*BITADDR +: BITADDR] == ent[EW-1 -: BITADDR]) dup = 1'b1;
            end
            if (!stop && ((BITFIFO+1)'(i) < cnt) && !dup) begin
                sel[i] = 1'b1;
                k      = k + 1'b1;
                lane_adr[i*BITADDR +: BITADDR] = ent[EW-1 -: BITADDR];
                lane_din[i*WIDTH +: WIDTH]     = ent[WIDTH-1:0];
            end else begin
                stop = 1'b1;
            end
        end
    end

    // State, pointers, occupancy and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            cl_rdy_q <= 1'b0;
            bp_thr_q <= '0;
            write_q  <= '0;
            wr_adr_q <= '0;
            din_q    <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rd_ptr <= rd_ptr + pop_cnt[BITFIFO-1:0];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            // Looking at the next count keeps a push from landing on a full queue.
            cl_rdy_q <= (state_nxt != INIT) && (cnt_nxt < (BITFIFO+1)'(FIFOCNT));
            write_q  <= issue_en ? sel : '0;
            wr_adr_q <= issue_en ? lane_adr : '0;
            din_q    <= issue_en ? lane_din : '0;
            if (state == INIT) bp_thr_q <= bus.cfg_thr;
        end
    end

    // Queue storage; contents are don't-care until the write pointer covers them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.cl_adr, bus.cl_din};
    end
endmodule
